// File: rtl/zynq_aes_pkg.sv
// Shared widths and types for the zynq_aes request ingress path.
package zynq_aes_pkg;

  localparam int WORD_S        = 32;
  localparam int BLK_S         = 128;
  localparam int WORDS_PER_BLK = BLK_S / WORD_S;
  localparam int CNT_W         = $clog2(WORDS_PER_BLK);

  // Packet parser state: first beat is the command, the rest is payload.
  typedef enum logic [0:0] {
    S_CMD  = 1'b0,
    S_DATA = 1'b1
  } rx_state_t;

  typedef logic [BLK_S-1:0] blk_t;

endpackage

// File: rtl/axis_blk_fifo.sv
// Small synchronous FIFO holding {blk_last, block} entries.
// The head is presented combinationally so an entry is visible the cycle
// after it is pushed; the output is forced to zero while empty.
module axis_blk_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 129
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // Full/empty come straight from the occupancy register, so tready has no
  // combinational path from the downstream pop.
  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, masked by empty.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Head entry, zero while nothing is queued.
  always_comb begin
    pop_data = '0;
    if (!empty) pop_data = mem[rd_ptr_reg];
  end

endmodule

// File: rtl/aes_axis_rx_assembler.sv
// Ingress assembler ahead of the AES controller: first beat of each packet
// is latched as a command, the remaining beats are packed four at a time into
// 128-bit blocks (first word in the MSBs) and queued in axis_blk_fifo.
// Optional feature macro: AXIS_RX_ERR_EN -- drop short trailing blocks and
// raise the sticky err_short flag instead of zero-padding them.
module aes_axis_rx_assembler
  import zynq_aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [WORD_S-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [WORD_S-1:0] cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [BLK_S-1:0]  blk_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              blk_last
`ifdef AXIS_RX_ERR_EN
  ,
  output logic              err_short
`endif
);

  rx_state_t                 state_reg;
  rx_state_t                 state_next;
  logic                      run_reg;
  logic [WORD_S-1:0]         cmd_data_reg;
  logic                      cmd_valid_reg;
  logic [CNT_W-1:0]          word_cnt_reg;
  logic [BLK_S-WORD_S-1:0]   asm_reg;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [BLK_S:0]            fifo_head;
  logic                      accept;
  logic                      cmd_accept;
  logic                      data_accept;
  logic                      blk_end;
  logic                      short_end;
  logic                      push;
  blk_t                      shifted;
  blk_t                      padded;

  assign accept      = s_axis_tvalid & s_axis_tready;
  assign cmd_accept  = accept & (state_reg == S_CMD);
  assign data_accept = accept & (state_reg == S_DATA);
  assign blk_end     = data_accept & (word_cnt_reg == CNT_W'(WORDS_PER_BLK - 1));
  assign short_end   = data_accept & s_axis_tlast & ~blk_end;

  // Newest word enters at the bottom; earlier words sit above it.
  assign shifted = {asm_reg, s_axis_tdata};

  // Move the received words up to the MSB end; missing low words become zero.
  assign padded = shifted << (WORD_S * (WORDS_PER_BLK - 1 - int'(word_cnt_reg)));

`ifdef AXIS_RX_ERR_EN
  assign push = blk_end;
`else
  assign push = blk_end | short_end;
`endif

  // Parser state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= S_CMD;
    else          state_reg <= state_next;
  end

  // Next state: tlast always returns to command parsing.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_CMD:   if (cmd_accept && !s_axis_tlast) state_next = S_DATA;
      S_DATA:  if (data_accept && s_axis_tlast) state_next = S_CMD;
      default: state_next = S_CMD;
    endcase
  end

  // Ready: a new command waits for the previous one to be taken; payload
  // waits for FIFO space. Held low until the first clock after reset.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state_reg)
      S_CMD:   s_axis_tready = run_reg & ~cmd_valid_reg;
      S_DATA:  s_axis_tready = run_reg & ~fifo_full;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // Command register, word counter and assembly shift register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_reg       <= 1'b0;
      cmd_data_reg  <= '0;
      cmd_valid_reg <= 1'b0;
      word_cnt_reg  <= '0;
      asm_reg       <= '0;
    end else begin
      run_reg <= 1'b1;
      if (cmd_accept) begin
        cmd_data_reg  <= s_axis_tdata;
        cmd_valid_reg <= 1'b1;
      end else if (cmd_valid_reg && cmd_ready) begin
        cmd_valid_reg <= 1'b0;
      end
      if (data_accept) begin
        asm_reg      <= shifted[BLK_S-WORD_S-1:0];
        word_cnt_reg <= s_axis_tlast ? '0 : word_cnt_reg + 1'b1;
      end
    end
  end

`ifdef AXIS_RX_ERR_EN
  logic err_short_reg;

  // Sticky short-packet flag, cleared only by reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)       err_short_reg <= 1'b0;
    else if (short_end) err_short_reg <= 1'b1;
  end

  assign err_short = err_short_reg;
`endif

  axis_blk_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BLK_S + 1)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data ({s_axis_tlast, padded}),
    .pop       (blk_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_data  = cmd_data_reg;
  assign cmd_valid = cmd_valid_reg;
  assign blk_valid = ~fifo_empty;
  assign blk_last  = fifo_head[BLK_S];
  assign blk_data  = fifo_head[BLK_S-1:0];

endmodule
